step_playback_engine: RTL
=========================

Name: step_playback_engine

Overview:
- Playback timing engine that sits directly downstream of the keyboard input interface.
- Consumes the interface's BPM, Loops and Start outputs and generates the step clock for the sequencer grid.
- Produces the current step index, a one-cycle pulse at each step and a completion pulse.
- Returns play_en to the input interface; when play_en drops, the interface leaves play mode.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- STEPS_PER_BEAT, 4: grid steps per beat (4 means 16th notes).
- NUM_STEPS, 16: steps per pattern pass; must be a power of two, at least 2.
- STEP_W, 4: width of step_idx; equals log2(NUM_STEPS).

Ports:
- CLOCK_50  in  1  system clock.
- nReset  in  1  reset, asynchronous, active-low.
- Start  in  1  level from the input interface; high while in play mode.
- BPM  in  10  tempo in beats per minute, 0..1023.
- Loops  in  7  number of pattern passes; 0 = play forever.
- play_en  out  1  high while the engine is playing.
- step_idx  out  STEP_W  current step, 0..NUM_STEPS-1.
- step_pulse  out  1  one-cycle strobe at the first cycle of every step.
- loop_count  out  7  completed passes in the current run.
- done  out  1  one-cycle strobe when a finite run completes.

Behaviour:
- Reset is asynchronous, active-low. All outputs go to 0, the state machine goes to IDLE, and the accumulator and latched values clear. Reset mid-play aborts immediately, with no done pulse.
- start_rise is derived from a registered copy of Start: Start is 1 this cycle and its registered copy is 0.
- States: IDLE, PLAYING, FINISH.
- IDLE:
  - play_en=0, step_pulse=0.
  - On start_rise with BPM!=0:
    - latch inc = BPM*STEPS_PER_BEAT (13-bit) and loops_l = Loops;
    - acc<=0, step_idx<=0, loop_count<=0;
    - go to PLAYING.
  - On start_rise with BPM==0: ignore and stay in IDLE.
- Entering PLAYING:
  - play_en=1 and step_pulse=1 on the first PLAYING cycle, which is one cycle after start_rise.
- PLAYING, every cycle:
  - THRESH = CLK_HZ*60 (32-bit constant).
  - s = acc + inc, computed at 33 bits with no overflow.
  - If s < THRESH: acc<=s, step_pulse<=0.
  - Else: acc<=s-THRESH and advance.
- Advance:
  - If step_idx != NUM_STEPS-1: step_idx+1, step_pulse<=1.
  - Else: step_idx<=0 and loop_count+1 (7-bit wrap, relevant only when Loops=0).
    - If loops_l!=0 and loop_count+1==loops_l: go to FINISH, with step_pulse<=0.
    - Otherwise: step_pulse<=1 and continue.
- FINISH, one cycle:
  - play_en=0, done=1, step_idx=0, and loop_count holds its final value.
  - Next cycle: IDLE with done=0.
- Abort: Start=0 while in PLAYING means go to IDLE next cycle.
  - play_en=0, step_idx=0, no done pulse.
  - loop_count holds its value.
- Changes to BPM or Loops during play are ignored; the values latched at start are used.
- Tempo jitter: step period is THRESH/inc cycles, which may be fractional. The accumulator dithers between the floor and ceiling cycle counts with no long-term drift.
- A new start_rise is honoured only from IDLE. After done, the input interface must drop Start and raise it again to replay.
- All outputs are registered with no combinational paths from input to output. The latency from start_rise to the first step_pulse is exactly 1 cycle.

Test Plan:
All scenarios use CLK_HZ=60, STEPS_PER_BEAT=4, NUM_STEPS=4, so THRESH=3600.
- Basic finite run:
  - Stimulus: BPM=150 (inc 600), Loops=2, raise Start at cycle T.
  - Response: play_en rises at T+1. step_pulse fires at T+1, T+7, ..., T+43 (8 pulses, step_idx 0,1,2,3,0,1,2,3). done=1 and play_en=0 at T+49. loop_count=2.
- Fractional tempo:
  - Stimulus: BPM=120 (inc 480), Loops=1.
  - Response: step periods alternate 8,7,8 cycles. done arrives 30 cycles after the first pulse.
- Infinite mode:
  - Stimulus: Loops=0, BPM=150; run 200 cycles, then drop Start.
  - Response: loop_count increments every 24 cycles. play_en falls 1 cycle after Start drops. No done pulse.
- Latch and BPM gate:
  - Stimulus: change BPM to 300 mid-run.
  - Response: period stays 6 cycles.
  - Stimulus: raise Start with BPM=0.
  - Response: play_en stays 0.
- Reset mid-play:
  - Stimulus: pulse nReset low between clock edges at step 2.
  - Response: all outputs are 0 immediately and the FSM is in IDLE. Holding Start high after reset does not restart play; a new rising edge is required.
- Restart after done:
  - Stimulus: hold Start high after done.
  - Response: no restart.
  - Stimulus: drop Start and raise it again.
  - Response: a new run begins with loop_count=0 and step_idx=0.

Source files
------------

// File: rtl/step_playback_engine.sv
// Step clock generator for the sequencer grid: a phase accumulator turns BPM into
// per-step strobes, counts pattern passes and reports completion of finite runs.
module step_playback_engine #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS_PER_BEAT = 4,
    parameter int NUM_STEPS      = 16,
    parameter int STEP_W         = 4
) (
    input  logic              CLOCK_50,
    input  logic              nReset,
    input  logic              Start,
    input  logic [9:0]        BPM,
    input  logic [6:0]        Loops,
    output logic              play_en,
    output logic [STEP_W-1:0] step_idx,
    output logic              step_pulse,
    output logic [6:0]        loop_count,
    output logic              done
);
    localparam longint            THRESH_L  = longint'(CLK_HZ) * 60;
    localparam logic [32:0]       THRESH    = 33'(THRESH_L);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, PLAYING, FINISH} state_t;

    state_t            state_reg, state_next;
    logic              start_q;
    logic [31:0]       acc_reg, acc_next;
    logic [12:0]       inc_reg, inc_next;
    logic [6:0]        loops_reg, loops_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [6:0]        lc_reg, lc_next;
    logic              pulse_reg, pulse_next;
    logic              play_reg, play_next;
    logic              done_reg, done_next;
    logic              start_rise;
    logic [32:0]       sum;
    logic [6:0]        lc_inc;

    assign start_rise = Start & ~start_q;
    assign sum        = {1'b0, acc_reg} + {20'd0, inc_reg};
    assign lc_inc     = lc_reg + 7'd1;

    // start_q comes out of reset high so a Start level held through reset is not a new edge
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_reg <= IDLE;
            start_q   <= 1'b1;
            acc_reg   <= '0;
            inc_reg   <= '0;
            loops_reg <= '0;
            step_reg  <= '0;
            lc_reg    <= '0;
            pulse_reg <= 1'b0;
            play_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_q   <= Start;
            acc_reg   <= acc_next;
            inc_reg   <= inc_next;
            loops_reg <= loops_next;
            step_reg  <= step_next;
            lc_reg    <= lc_next;
            pulse_reg <= pulse_next;
            play_reg  <= play_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        inc_next   = inc_reg;
        loops_next = loops_reg;
        step_next  = step_reg;
        lc_next    = lc_reg;
        pulse_next = 1'b0;
        play_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_rise && (BPM != 10'd0)) begin
                    inc_next   = 13'({3'b000, BPM} * 13'(STEPS_PER_BEAT));
                    loops_next = Loops;
                    acc_next   = '0;
                    step_next  = '0;
                    lc_next    = '0;
                    state_next = PLAYING;
                    play_next  = 1'b1;
                    pulse_next = 1'b1;
                end
            end
            PLAYING: begin
                play_next = 1'b1;
                if (!Start) begin
                    state_next = IDLE;
                    play_next  = 1'b0;
                    step_next  = '0;
                end else if (sum < THRESH) begin
                    acc_next = sum[31:0];
                end else begin
                    // keep the remainder so fractional periods average out exactly
                    acc_next = 32'(sum - THRESH);
                    if (step_reg != LAST_STEP) begin
                        step_next  = step_reg + STEP_W'(1);
                        pulse_next = 1'b1;
                    end else begin
                        step_next = '0;
                        lc_next   = lc_inc;
                        if ((loops_reg != 7'd0) && (lc_inc == loops_reg)) begin
                            state_next = FINISH;
                            play_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            pulse_next = 1'b1;
                        end
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign play_en    = play_reg;
    assign step_idx   = step_reg;
    assign step_pulse = pulse_reg;
    assign loop_count = lc_reg;
    assign done       = done_reg;
endmodule
